uart_tx_top: RTL and testbench

UART transmit path: a CPU-side write register feeds a 2**W x B FIFO, and a baud-timed serializer drains it onto the serial line. Frames are 8N1: start bit 0, 8 data bits LSB first, stop bit 1. The block sits beside the receive path and shares its register-style interface and baud_div convention: one bit period equals baud_div clk_i cycles.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx_top.sv | 156 +++++++++++++++
 tb/tb_uart_tx_top.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART transmit path.
//   tx_state_t     : serializer FSM state encoding
//   UART_DATA_BITS : data bits per 8N1 frame
//   START_BIT      : line level during the start bit
//   STOP_BIT       : line level during the stop bit (and idle)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// fifo_uart_tx
// Synchronous FIFO of 2**W words of B bits. The head word is presented
// combinationally on rdata. A write while full is dropped, and a read
// while empty is ignored. Full/empty are decoded from the registered count.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   wr_en, wdata : push strobe and data
//   rd_en        : pop strobe
//   rdata        : head word (combinational)
//   full, empty  : occupancy flags
module fifo_uart_tx #(
    parameter int W = 4,
    parameter int B = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en,
    input  logic [B-1:0] wdata,
    input  logic         rd_en,
    output logic [B-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    logic [B-1:0] r_mem [2**W];
    logic [W-1:0] r_wr_ptr;
    logic [W-1:0] r_rd_ptr;
    logic [W:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign full   = (r_count == DEPTH);
    assign empty  = (r_count == '0);
    // Flags come from the pre-edge count, so a write while full is dropped
    // even if a pop happens on the same edge.
    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly W bits wide, so they wrap modulo 2**W on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// uart_tx_top
// UART 8N1 transmitter: a CPU write register feeds a FIFO, and a baud-timed
// serializer drains it. One bit period lasts baud_div clk_i cycles (0 acts as 1).
//   clk_i, rst_i                        : clock, asynchronous active-high reset
//   UART_Control_Register_tx_Active     : allows popping/starting new frames
//   UART_Data_Write_Register_enable     : one-cycle write strobe
//   UART_Data_Write_Register_wdata      : byte to enqueue
//   baud_div                            : clk_i cycles per bit
//   uart_tx_o                           : serial line, idles high
//   UART_Status_Register_tx_full/empty  : FIFO occupancy flags
//   UART_Tx_Busy                        : frame on the line
//   UART_Tx_Done                        : pulse on the last stop-bit cycle
//
// state | meaning
// IDLE  | line high; start a frame when active and FIFO not empty
// START | drive start bit for one bit period
// DATA  | drive shreg[idx], LSB first, one bit period each
// STOP  | drive stop bit; Done on its final cycle
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int W = 4,
    parameter int B = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        UART_Control_Register_tx_Active,
    input  logic        UART_Data_Write_Register_enable,
    input  logic [7:0]  UART_Data_Write_Register_wdata,
    input  logic [15:0] baud_div,
    output logic        uart_tx_o,
    output logic        UART_Status_Register_tx_full,
    output logic        UART_Status_Register_tx_empty,
    output logic        UART_Tx_Busy,
    output logic        UART_Tx_Done
);

    tx_state_t    r_state, w_state_nx;
    logic [15:0]  r_cnt, w_cnt_nx;
    logic [15:0]  r_baud, w_baud_nx;
    logic [2:0]   r_idx, w_idx_nx;
    logic [B-1:0] r_shreg, w_shreg_nx;
    logic         r_tx, w_tx_nx;
    logic         r_busy, w_busy_nx;
    logic         r_done, w_done_nx;
    logic         w_pop;
    logic [B-1:0] w_head;
    logic         w_full, w_empty;
    logic [15:0]  w_baud_eff;

    fifo_uart_tx #(.W(W), .B(B)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_en (UART_Data_Write_Register_enable),
        .wdata (UART_Data_Write_Register_wdata),
        .rd_en (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_baud_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;

    // r_cnt is a down-counter: it is loaded with period-1 on each bit entry
    // and the bit ends on the cycle it reads zero.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_baud_nx  = r_baud;
        w_idx_nx   = r_idx;
        w_shreg_nx = r_shreg;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nx = STOP_BIT;
                if (UART_Control_Register_tx_Active && !w_empty) begin
                    w_pop      = 1'b1;
                    w_shreg_nx = w_head;
                    w_baud_nx  = w_baud_eff;
                    w_cnt_nx   = w_baud_eff - 16'd1;
                    w_tx_nx    = START_BIT;
                    w_state_nx = START;
                end
            end
            START: begin
                if (r_cnt == 16'd0) begin
                    w_state_nx = DATA;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = r_shreg[0];
                    w_cnt_nx   = r_baud - 16'd1;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            DATA: begin
                if (r_cnt == 16'd0) begin
                    w_cnt_nx = r_baud - 16'd1;
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_state_nx = STOP;
                        w_tx_nx    = STOP_BIT;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                        w_tx_nx  = r_shreg[r_idx + 3'd1];
                    end
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            STOP: begin
                w_tx_nx = STOP_BIT;
                if (r_cnt == 16'd0) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_tx_nx    = STOP_BIT;
            end
        endcase
        // Busy/Done are registered, so decode them from the next state.
        w_busy_nx = (w_state_nx != IDLE);
        w_done_nx = (w_state_nx == STOP) && (w_cnt_nx == 16'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_baud  <= 16'd1;
            r_idx   <= '0;
            r_shreg <= '0;
            r_tx    <= STOP_BIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_baud  <= w_baud_nx;
            r_idx   <= w_idx_nx;
            r_shreg <= w_shreg_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign uart_tx_o                     = r_tx;
    assign UART_Tx_Busy                  = r_busy;
    assign UART_Tx_Done                  = r_done;
    assign UART_Status_Register_tx_full  = w_full;
    assign UART_Status_Register_tx_empty = w_empty;

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top
// Stimulus pushes each byte expected on the line into exp_q; a monitor
// decodes frames from uart_tx_o, pops and compares, and checks Done timing.
module tb_uart_tx_top;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tx_active = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] baud_div = 16'd4;
    logic        uart_tx_o;
    logic        tx_full, tx_empty, tx_busy, tx_done;

    uart_tx_top #(.W(4), .B(8)) dut (
        .clk_i                           (clk_i),
        .rst_i                           (rst_i),
        .UART_Control_Register_tx_Active (tx_active),
        .UART_Data_Write_Register_enable (wr_en),
        .UART_Data_Write_Register_wdata  (wdata),
        .baud_div                        (baud_div),
        .uart_tx_o                       (uart_tx_o),
        .UART_Status_Register_tx_full    (tx_full),
        .UART_Status_Register_tx_empty   (tx_empty),
        .UART_Tx_Busy                    (tx_busy),
        .UART_Tx_Done                    (tx_done)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cur_baud = 4;
    int frames_seen = 0;
    int start_prev = 0;
    int start_last = 0;
    logic abort_req = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: frame begins on the first low sample of an idle line.
    int         m_b, m_done_cnt, m_done_at, m_k;
    logic [7:0] m_byte, m_exp;
    logic       m_start, m_stop, m_abort;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && uart_tx_o == 1'b0) begin
                m_b = cur_baud;
                m_byte = 8'h00; m_start = 1'b1; m_stop = 1'b0; m_abort = 1'b0;
                m_done_cnt = 0; m_done_at = -1;
                start_prev = start_last;
                start_last = cyc;
                for (int c = 0; c < 10 * m_b; c++) begin
                    if (c != 0) @(negedge clk_i);
                    if (abort_req) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (tx_done) begin
                        m_done_cnt++;
                        m_done_at = c;
                    end
                    if (c % m_b == m_b / 2) begin
                        m_k = c / m_b;
                        if (m_k == 0)      m_start = uart_tx_o;
                        else if (m_k <= 8) m_byte = {uart_tx_o, m_byte[7:1]};
                        else               m_stop = uart_tx_o;
                    end
                end
                if (m_abort) begin
                    abort_req = 1'b0;
                end else begin
                    frames_seen++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_unexpected: got byte %02h expected none", m_byte);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("frame_byte", int'(m_byte), int'(m_exp));
                    end
                    chk("frame_start_bit", int'(m_start), 0);
                    chk("frame_stop_bit", int'(m_stop), 1);
                    chk("done_pulse_count", m_done_cnt, 1);
                    chk("done_pulse_cycle", m_done_at, 10 * m_b - 1);
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk_i);
        wr_en = 1'b1;
        wdata = d;
        @(negedge clk_i);
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("frame_wait_timeout", int'(frames_seen >= target), 1);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!tx_busy && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("busy_wait_timeout", int'(tx_busy), 1);
    endtask

    int f0, lows, n;

    initial begin
        // Reset state
        #12;
        chk("rst_tx", int'(uart_tx_o), 1);
        chk("rst_empty", int'(tx_empty), 1);
        chk("rst_full", int'(tx_full), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single byte 0xA5 at baud 4
        baud_div = 16'd4; cur_baud = 4; tx_active = 1'b1;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        chk("single_empty_after_write", int'(tx_empty), 0);
        @(negedge clk_i);
        chk("single_empty_after_pop", int'(tx_empty), 1);
        chk("single_busy", int'(tx_busy), 1);
        wait_frames(1, 100);

        // Fill / overflow with TX disabled
        repeat (3) @(negedge clk_i);
        tx_active = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            write_byte(8'(i));
            if (i == 14) chk("fill_not_full_15", int'(tx_full), 0);
            if (i == 15) chk("fill_full_16", int'(tx_full), 1);
        end
        chk("fill_full_after_17", int'(tx_full), 1);
        chk("fill_not_empty", int'(tx_empty), 0);
        tx_active = 1'b1;
        wait_frames(frames_seen + 16, 16 * 45 + 20);
        chk("fill_drained_empty", int'(tx_empty), 1);

        // Back-to-back at baud 868
        repeat (3) @(negedge clk_i);
        tx_active = 1'b0;
        baud_div = 16'd868; cur_baud = 868;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        write_byte(8'h55);
        write_byte(8'h3C);
        f0 = frames_seen;
        tx_active = 1'b1;
        n = 0;
        while (!tx_done && n < 9000) begin
            @(negedge clk_i);
            n++;
        end
        chk("b2b_done_seen", int'(tx_done), 1);
        @(negedge clk_i);
        chk("b2b_gap_busy_low", int'(tx_busy), 0);
        chk("b2b_gap_line_high", int'(uart_tx_o), 1);
        @(negedge clk_i);
        chk("b2b_second_busy", int'(tx_busy), 1);
        wait_frames(f0 + 2, 18000);
        chk("b2b_start_spacing", start_last - start_prev, 8681);

        // Pause mid-frame: 0x81 completes, 0x7E stays queued
        repeat (3) @(negedge clk_i);
        tx_active = 1'b0;
        baud_div = 16'd4; cur_baud = 4;
        exp_q.push_back(8'h81);
        write_byte(8'h81);
        write_byte(8'h7E);
        f0 = frames_seen;
        tx_active = 1'b1;
        wait_busy(10);
        repeat (17) @(negedge clk_i);
        tx_active = 1'b0;
        wait_frames(f0 + 1, 100);
        repeat (20) @(negedge clk_i);
        chk("pause_busy", int'(tx_busy), 0);
        chk("pause_line_high", int'(uart_tx_o), 1);
        chk("pause_not_empty", int'(tx_empty), 0);
        exp_q.push_back(8'h7E);
        tx_active = 1'b1;
        wait_frames(f0 + 2, 100);

        // Async reset during DATA of 0xF0
        repeat (3) @(negedge clk_i);
        write_byte(8'hF0);
        wait_busy(10);
        repeat (10) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        abort_req = 1'b1;
        #1;
        chk("arst_line_high", int'(uart_tx_o), 1);
        chk("arst_busy", int'(tx_busy), 0);
        chk("arst_empty", int'(tx_empty), 1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        f0 = frames_seen;
        lows = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (uart_tx_o == 1'b0) lows++;
        end
        abort_req = 1'b0;
        chk("arst_no_residual_low", lows, 0);
        chk("arst_no_residual_frame", frames_seen, f0);

        // baud_div = 0 behaves as 1
        baud_div = 16'd0; cur_baud = 1;
        exp_q.push_back(8'h01);
        f0 = frames_seen;
        write_byte(8'h01);
        wait_frames(f0 + 1, 40);

        repeat (5) @(negedge clk_i);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
